holdline: RTL

Programmable off-delay (pulse-stretch) element, the counterpart of the on-delay line used in the utility library. It is used wherever a level must rise promptly and fall only after a quiet period, for example link-activity and request-pending flags. The output asserts one cycle after the input rises. It deasserts `hold` cycles after the input falls, and any re-assertion during the hold period cancels the fall. Saturating event and retrigger counters are provided for debug and status registers.

---
 rtl/holdline_pkg.sv | 21 ++
 rtl/holdline_if.sv | 25 ++
 rtl/holdline_sat_counter.sv | 35 +++
 rtl/holdline.sv | 116 +++++++++++
 4 files changed

// File: rtl/holdline_pkg.sv
// Shared definitions for the holdline off-delay element: state encodings and
// small decode helpers used by the FSM and its status outputs.
package holdline_pkg;

    localparam int HL_STATE_W = 2;

    localparam logic [HL_STATE_W-1:0] HL_IDLE = 2'd0;
    localparam logic [HL_STATE_W-1:0] HL_ON   = 2'd1;
    localparam logic [HL_STATE_W-1:0] HL_HOLD = 2'd2;

    // Everything except IDLE counts as busy, including the unreachable
    // encoding, so a corrupted state is visible on the status output.
    function automatic logic hl_busy(input logic [HL_STATE_W-1:0] s);
        return (s != HL_IDLE);
    endfunction

    function automatic logic hl_in_hold(input logic [HL_STATE_W-1:0] s);
        return (s == HL_HOLD);
    endfunction

endpackage

// File: rtl/holdline_if.sv
// Control/status bundle of the holdline element. The slave side is the
// stretcher itself; the master side drives the level and reads status.
interface holdline_if #(
    parameter int HOLD_WIDTH = 9,
    parameter int CNT_WIDTH  = 16
);
    logic                  in;
    logic [HOLD_WIDTH-1:0] hold;
    logic                  clr;
    logic                  out;
    logic                  busy;
    logic [HOLD_WIDTH-1:0] remain;
    logic [CNT_WIDTH-1:0]  pulses;
    logic [CNT_WIDTH-1:0]  retrig;

    modport master (
        output in, hold, clr,
        input  out, busy, remain, pulses, retrig
    );

    modport slave (
        input  in, hold, clr,
        output out, busy, remain, pulses, retrig
    );
endinterface

// File: rtl/holdline_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a same-cycle
// increment. Reusable status/debug counter.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && !(&q_q)) begin
            q_d = q_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/holdline.sv
// Programmable off-delay (pulse stretch): output rises one cycle after the
// input and falls 'hold' cycles after it drops, unless re-asserted meanwhile.
module holdline #(
    parameter int HOLD_WIDTH = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic       clk,
    input  logic       reset_,
    holdline_if.slave  bus
);
    import holdline_pkg::*;

    localparam logic [HOLD_WIDTH-1:0] HOLD_ONE = {{(HOLD_WIDTH-1){1'b0}}, 1'b1};

    logic [HL_STATE_W-1:0] state_q;
    logic [HL_STATE_W-1:0] state_d;
    logic [HOLD_WIDTH-1:0] cnt_q;
    logic [HOLD_WIDTH-1:0] cnt_d;
    logic                  out_q;
    logic                  out_d;
    logic                  pulse_inc;
    logic                  retrig_inc;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        pulse_inc  = 1'b0;
        retrig_inc = 1'b0;

        case (state_q)
            HL_IDLE: begin
                out_d = 1'b0;
                cnt_d = '0;
                if (bus.in) begin
                    state_d   = HL_ON;
                    out_d     = 1'b1;
                    pulse_inc = 1'b1;
                end
            end

            HL_ON: begin
                out_d = 1'b1;
                if (!bus.in) begin
                    // hold is latched here only; later changes do not
                    // affect the fall that is already being timed.
                    if (bus.hold == '0) begin
                        state_d = HL_IDLE;
                        out_d   = 1'b0;
                    end else begin
                        state_d = HL_HOLD;
                        cnt_d   = bus.hold - HOLD_ONE;
                    end
                end
            end

            HL_HOLD: begin
                out_d = 1'b1;
                if (bus.in) begin
                    state_d    = HL_ON;
                    cnt_d      = '0;
                    retrig_inc = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = HL_IDLE;
                    out_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - HOLD_ONE;
                end
            end

            default: begin
                state_d = HL_IDLE;
                out_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= HL_IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    // Status outputs decode registers only, never the live input.
    assign bus.out    = out_q;
    assign bus.busy   = hl_busy(state_q);
    assign bus.remain = hl_in_hold(state_q) ? cnt_q : '0;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_pulses (
        .clk    (clk),
        .reset_ (reset_),
        .inc    (pulse_inc),
        .clr    (bus.clr),
        .q      (bus.pulses)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_retrig (
        .clk    (clk),
        .reset_ (reset_),
        .inc    (retrig_inc),
        .clr    (bus.clr),
        .q      (bus.retrig)
    );

endmodule
